// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Each bit is held for CLKS_PER_BIT enabled clock cycles; en=0 stretches the current bit.
module serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TMR_W = 8;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic              parity_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              bit_end;

  assign bit_end = en && (timer_q == TMR_LAST);
  assign shreg_d = shreg_q >> 1;

  // tx is loaded with the value of the bit being entered, so the line never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && en) begin
        timer_q <= bit_end ? '0 : timer_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (valid) begin
            shreg_q  <= data_in;
            parity_q <= ^data_in;
            timer_q  <= '0;
            idx_q    <= '0;
            state_q  <= START;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shreg_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg_q <= shreg_d;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q <= shreg_d[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: parity and no-parity instances, scoreboard of accepted words,
// monitor checks the line cycle by cycle against the frame rules.
module tb_serial_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned DW  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] valid_v;
  logic [7:0] data_p;
  logic [7:0] data_n;
  logic [1:0] ready_v;
  logic [1:0] tx_v;
  logic [1:0] busy_v;
  logic [1:0] done_v;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // monitor state, index 0 = parity instance, 1 = no-parity instance
  logic [7:0] cur_w    [2];
  int         bidx     [2];
  int         cnt      [2];
  int         len      [2];
  int         stall    [2];
  int         idle_cnt [2];
  int         last_len [2];
  int         last_gap [2];
  bit         in_frame [2];
  bit         pend_done[2];

  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .en(en), .data_in(data_p), .valid(valid_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_EN(0)) dut_n (
    .clk(clk), .rst(rst), .en(en), .data_in(data_n), .valid(valid_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbits(input int i);
    return (i == 0) ? (DW + 3) : (DW + 2);
  endfunction

  // Frame as a list of bit slots: start, data LSB first, even parity (if any), stop
  function automatic logic exp_bit(input logic [7:0] w, input int i, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if ((i == 0) && (b == DW + 1)) return ^w;
    return 1'b1;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_frame[i] = 0; pend_done[i] = 0; idle_cnt[i] = 0;
      last_len[i] = 0; last_gap[i] = -1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        in_frame[i]  = 0;
        pend_done[i] = 0;
        idle_cnt[i]  = 0;
      end else begin
        if (pend_done[i]) begin
          chk($sformatf("done_pulse%0d", i), int'(done_v[i]), 1);
          chk($sformatf("done_busy%0d", i), int'(busy_v[i]), 0);
          chk($sformatf("frame_len%0d", i), len[i], nbits(i) * CPB + stall[i]);
          last_len[i]  = len[i];
          pend_done[i] = 0;
        end else begin
          chk($sformatf("done_low%0d", i), int'(done_v[i]), 0);
        end
        if (!in_frame[i] && busy_v[i]) begin
          if (i == 0) begin
            chk("frame_expected0", int'(q0.size() != 0), 1);
            cur_w[i] = (q0.size() != 0) ? q0.pop_front() : 8'h00;
          end else begin
            chk("frame_expected1", int'(q1.size() != 0), 1);
            cur_w[i] = (q1.size() != 0) ? q1.pop_front() : 8'h00;
          end
          in_frame[i] = 1;
          bidx[i] = 0; cnt[i] = 0; len[i] = 0; stall[i] = 0;
          last_gap[i] = idle_cnt[i];
          idle_cnt[i] = 0;
        end
        if (in_frame[i]) begin
          chk($sformatf("tx%0d_bit%0d", i, bidx[i]), int'(tx_v[i]),
              int'(exp_bit(cur_w[i], i, bidx[i])));
          chk($sformatf("busy%0d", i), int'(busy_v[i]), 1);
          chk($sformatf("ready_low%0d", i), int'(ready_v[i]), 0);
          len[i]++;
          if (en) cnt[i]++; else stall[i]++;
          if (cnt[i] == CPB) begin
            cnt[i] = 0;
            bidx[i]++;
            if (bidx[i] == nbits(i)) begin
              in_frame[i]  = 0;
              pend_done[i] = 1;
            end
          end
        end else begin
          idle_cnt[i]++;
          chk($sformatf("idle_tx%0d", i), int'(tx_v[i]), 1);
          chk($sformatf("idle_ready%0d", i), int'(ready_v[i]), 1);
        end
      end
    end
  end

  task automatic send(input int sel, input logic [7:0] w, input bit hold);
    int t;
    if (sel == 0) data_p = w; else data_n = w;
    valid_v[sel] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ready_v[sel] && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", int'(t < 300), 1);
    @(posedge clk);
    if (sel == 0) q0.push_back(w); else q1.push_back(w);
    #1;
    if (!hold) valid_v[sel] = 1'b0;
  endtask

  task automatic run_until_idle(input bit rnd);
    int t;
    t = 0;
    do begin
      @(posedge clk); #1;
      if (rnd) en = ($urandom_range(0, 3) != 0);
      t++;
    end while (((busy_v != 2'b00) || (q0.size() != 0) || (q1.size() != 0)) && t < 3000);
    en = 1'b1;
    chk("idle_timeout", int'(t < 3000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b0; en = 1'b1; valid_v = 2'b00; data_p = 8'h00; data_n = 8'h00;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_tx%0d", i), int'(tx_v[i]), 1);
      chk($sformatf("rst_ready%0d", i), int'(ready_v[i]), 1);
      chk($sformatf("rst_busy%0d", i), int'(busy_v[i]), 0);
      chk($sformatf("rst_done%0d", i), int'(done_v[i]), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(0, 8'hA5, 0);
    run_until_idle(0);
    chk("a5_len", last_len[0], 44);

    send(0, 8'h01, 0);
    run_until_idle(0);
    chk("p01_len", last_len[0], 44);
    send(1, 8'h01, 0);
    run_until_idle(0);
    chk("np01_len", last_len[1], 40);

    // en low for three cycles inside data bit 2
    send(0, 8'($urandom), 0);
    repeat (13) @(posedge clk);
    #1 en = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    run_until_idle(0);
    chk("stall_len", last_len[0], 47);

    // asynchronous reset inside data bit 4
    send(0, 8'($urandom), 0);
    repeat (21) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", int'(tx_v[0]), 1);
    chk("mid_rst_busy", int'(busy_v[0]), 0);
    chk("mid_rst_ready", int'(ready_v[0]), 1);
    chk("mid_rst_done", int'(done_v[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 8'h3C, 0);
    run_until_idle(0);
    chk("3c_len", last_len[0], 44);

    send(0, 8'h11, 1);
    send(0, 8'h22, 0);
    run_until_idle(0);
    chk("b2b_gap", last_gap[0], 1);

    // valid pulse with 0xFF while a frame is in flight
    send(0, 8'($urandom), 0);
    repeat (8) @(posedge clk);
    #1 data_p = 8'hFF; valid_v[0] = 1'b1;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    run_until_idle(0);
    chk("busy_ignore_len", last_len[0], 44);

    for (int k = 0; k < 10; k++) begin
      w = 8'($urandom);
      send(k % 2, w, 0);
      run_until_idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, the number of enabled clock cycles each serial bit is held (legal range 1..255).
REQ-002 SHALL have parameter DATA_W, default 8, the payload width in bits.
REQ-003 SHALL have parameter PARITY_EN, default 1; 1 inserts an even-parity bit after the data bits, 0 omits it.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1 bit, bit-timer enable; en=0 freezes the timer and state, holding tx at its current value.
REQ-007 SHALL have port data_in, input, DATA_W bits, the word to transmit, sampled on the accept edge.
REQ-008 SHALL have port valid, input, 1 bit; the source has a word on data_in.
REQ-009 SHALL have port ready, output, 1 bit; the block can accept a word.
REQ-010 SHALL have port tx, output, 1 bit, the registered serial line; it idles high.
REQ-011 SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle pulse on frame completion.

Function
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-014 SHALL drive ready=1 exactly when the state is IDLE; ready SHALL NOT depend combinationally on valid.
REQ-015 SHALL accept a word on a rising edge where valid=1, ready=1 and rst=0, regardless of en.
- On accept, SHALL register data_in into the shift register and compute parity as the XOR of all data bits.
- On accept, SHALL clear the bit timer and enter START.
REQ-016 SHALL ignore data_in and valid while not in IDLE; a held valid is accepted in the next IDLE cycle.
REQ-017 SHALL drive tx as follows in each state:
- START: 0.
- DATA: data bits, LSB first.
- PARITY: the parity bit.
- STOP: 1.
- IDLE: 1.
REQ-018 SHALL increment the bit timer only on cycles with en=1; a bit SHALL end when the timer reaches CLKS_PER_BIT-1 with en=1, and the timer SHALL then wrap to 0.
REQ-019 SHALL shift the data register right and increment the bit index at the end of each DATA bit.
- After bit DATA_W-1, the next state SHALL be PARITY if PARITY_EN=1, otherwise STOP.
REQ-020 SHALL go from PARITY to STOP at the end of the parity bit, and from STOP to IDLE at the end of the stop bit.
REQ-021 SHALL pulse done=1 for the single cycle following the STOP-to-IDLE edge; ready SHALL be 1 in that same cycle.
REQ-022 SHALL hold busy=1 in START, DATA, PARITY and STOP, and busy=0 in IDLE.
REQ-023 SHALL give frame duration, with en held at 1, of (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles from the first START cycle to the first IDLE cycle.
- With default parameters this is 44 cycles.
REQ-024 SHALL enforce a minimum of one IDLE cycle between consecutive frames.
REQ-025 SHALL, when en=0 in mid-bit, extend the current bit by the number of disabled cycles, with no glitch on tx.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-frame, immediately and without waiting for clk set:
- state=IDLE, tx=1, ready=1, busy=0, done=0;
- bit timer, bit index, shift register and parity all 0.
REQ-027 SHALL perform no accept while rst=1, and SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-028 SHALL pass the basic-frame case:
- Stimulus: defaults, en=1, send 0xA5.
- Required tx, 4 cycles per bit: 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1.
- Required control: done pulses 44 cycles after the first START cycle; ready=0 throughout the frame.
REQ-029 SHALL pass the parity case: send 0x01 with PARITY_EN=1, then 0x01 with PARITY_EN=0.
- PARITY_EN=1: parity bit=1.
- PARITY_EN=0: stop bit follows data bit 7 directly; frame is 40 cycles.
REQ-030 SHALL pass the enable-stall case: drop en for 3 cycles during data bit 2.
- That bit lasts 7 cycles.
- Frame is 47 cycles.
- Bit values are unchanged.
REQ-031 SHALL pass the mid-frame-reset case: assert rst asynchronously (between clk edges) during data bit 4.
- tx=1, busy=0, ready=1 before the next clk edge.
- A subsequent send of 0x3C is transmitted correctly.
REQ-032 SHALL pass the back-to-back case: hold valid=1 with 0x11 then 0x22.
- The second word is accepted in the cycle done=1.
- Exactly one IDLE cycle (tx=1) separates the two frames.
REQ-033 SHALL pass the ignore-while-busy case: pulse valid with 0xFF during DATA.
- The pulse has no effect.
- The in-flight word is transmitted intact.
